ngs_boot_tick_master: RTL and testbench

Avalon-MM initiator that drives the system interval timer from hardware, with no CPU involvement. On a start request it programs the timer's period and control registers, then services every timer interrupt by clearing the timer status and counting ticks. On a stop request it halts the timer. It sits beside the boot core's timer slave on the same 16-bit register port and gives boot-time logic a free-running tick count before any firmware runs.

---
 rtl/ngs_boot_tick_master.sv | 177 +++++++++++++++++
 tb/tb_ngs_boot_tick_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ngs_boot_tick_master.sv
// ngs_boot_tick_master: Avalon-MM initiator that programs the interval timer at boot and counts its ticks.
// Define NGS_BOOT_TICK_MASTER_SNAP_EN to add hardware snapshots of the timer counter (snap_* ports).
module ngs_boot_tick_master #(
  parameter logic [31:0] PERIOD     = 32'd24999,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic        irq,
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
  input  logic        snap_req,
  output logic        snap_valid,
  output logic [31:0] snap_value,
`endif
  output logic        busy,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count
);

  localparam logic [2:0]  A_STATUS   = 3'd0;
  localparam logic [2:0]  A_CONTROL  = 3'd1;
  localparam logic [2:0]  A_PERIOD_L = 3'd2;
  localparam logic [2:0]  A_PERIOD_H = 3'd3;
  localparam logic [15:0] CTL_START  = {12'h000, 1'b0, 1'b1, CONTINUOUS, 1'b1};
  localparam logic [15:0] CTL_STOP   = 16'h0008;

  typedef enum logic [3:0] {
    IDLE, CFG_PL, CFG_PH, CFG_CTL, RUN, ACK, HALT
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
    , SNAP_W, SNAP_RL, SNAP_CL, SNAP_RH, SNAP_CH
`endif
  } state_t;

  typedef struct packed {
    logic        cs;
    logic [2:0]  addr;
    logic        we_n;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, addr: 3'd0, we_n: 1'b1, wdata: 16'h0000};

  function automatic bus_t bus_write(logic [2:0] a, logic [15:0] d);
    return '{cs: 1'b1, addr: a, we_n: 1'b0, wdata: d};
  endfunction

  function automatic bus_t bus_read(logic [2:0] a);
    return '{cs: 1'b1, addr: a, we_n: 1'b1, wdata: 16'h0000};
  endfunction

  // Bus cycle each state presents; a stalled state keeps presenting the identical cycle.
  function automatic bus_t bus_for(state_t s);
    bus_t b;
    case (s)
      CFG_PL:  b = bus_write(A_PERIOD_L, PERIOD[15:0]);
      CFG_PH:  b = bus_write(A_PERIOD_H, PERIOD[31:16]);
      CFG_CTL: b = bus_write(A_CONTROL, CTL_START);
      ACK:     b = bus_write(A_STATUS, 16'h0000);
      HALT:    b = bus_write(A_CONTROL, CTL_STOP);
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      SNAP_W:  b = bus_write(3'd4, 16'h0000);
      SNAP_RL: b = bus_read(3'd4);
      SNAP_RH: b = bus_read(3'd5);
`endif
      default: b = BUS_IDLE;
    endcase
    return b;
  endfunction

  state_t state, next_state;
  bus_t   bus_q;
  logic   pending_stop;
  logic   accepted;
  logic   stop_now;

  assign accepted = bus_q.cs && !m_waitrequest;
  assign stop_now = pending_stop || stop;

  always_comb begin
    // NOTE: next_state gets its default before the case, so no path can leave it unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (start)    next_state = CFG_PL;
      CFG_PL:  if (accepted) next_state = stop_now ? HALT : CFG_PH;
      CFG_PH:  if (accepted) next_state = stop_now ? HALT : CFG_CTL;
      CFG_CTL: if (accepted) next_state = stop_now ? HALT : RUN;
      RUN: begin
        if (stop)          next_state = HALT;
        else if (irq)      next_state = ACK;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
        else if (snap_req) next_state = SNAP_W;
`endif
      end
      ACK:     if (accepted) next_state = stop_now ? HALT : RUN;
      HALT:    if (accepted) next_state = IDLE;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      SNAP_W:  if (accepted) next_state = SNAP_RL;
      SNAP_RL: if (accepted) next_state = SNAP_CL;
      SNAP_CL: next_state = SNAP_RH;
      SNAP_RH: if (accepted) next_state = SNAP_CH;
      SNAP_CH: next_state = stop_now ? HALT : RUN;
`endif
      default: next_state = IDLE;
    endcase
  end

`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
  logic [15:0] snap_low;
`else
  logic unused_readdata;
  assign unused_readdata = ^m_readdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus_q        <= BUS_IDLE;
      busy         <= 1'b0;
      running      <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
      pending_stop <= 1'b0;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      snap_low     <= '0;
      snap_valid   <= 1'b0;
      snap_value   <= '0;
`endif
    end else begin
      // NOTE: every register here uses <=, so all decisions in this edge see the pre-edge state.
      state <= next_state;
      bus_q <= bus_for(next_state);
      busy  <= !(next_state == IDLE || next_state == RUN);
      tick  <= (state == ACK) && accepted;

      if (state == IDLE && start)
        tick_count <= '0;
      else if (state == ACK && accepted)
        tick_count <= tick_count + 32'd1;

      if (state == CFG_CTL && next_state == RUN)
        running <= 1'b1;
      else if (state == HALT && accepted)
        running <= 1'b0;

      // busy mirrors the current state being neither IDLE nor RUN: a stop there must wait its turn.
      if (next_state == HALT || next_state == IDLE)
        pending_stop <= 1'b0;
      else if (stop && busy)
        pending_stop <= 1'b1;

`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      snap_valid <= 1'b0;
      if (state == SNAP_CL)
        snap_low <= m_readdata;
      if (state == SNAP_CH) begin
        snap_value <= {m_readdata, snap_low};
        snap_valid <= 1'b1;
      end
`endif
    end
  end

  assign m_chipselect = bus_q.cs;
  assign m_address    = bus_q.addr;
  assign m_write_n    = bus_q.we_n;
  assign m_writedata  = bus_q.wdata;

endmodule

// File: tb/tb_ngs_boot_tick_master.sv
// Bench for ngs_boot_tick_master: timer slave model, transaction log, per-cycle model compare and directed tests.
// The snapshot test is built only when NGS_BOOT_TICK_MASTER_SNAP_EN is defined.
module tb_ngs_boot_tick_master;

  localparam logic [31:0] PERIOD    = 32'd24999;
  localparam logic [31:0] TIMER_NOW = 32'h0001_2345;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = 16'hDEAD;
  logic        m_waitrequest = 1'b0;
  logic        irq = 1'b0;
  logic        busy;
  logic        running;
  logic        tick;
  logic [31:0] tick_count;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
  logic        snap_req = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_value;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tick_seen = 0;
  logic irq_req = 1'b0;
  logic irq_clr = 1'b0;
  logic [31:0] slave_lat = 32'h0;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic        wr;
    logic [15:0] data;
  } txn_t;
  txn_t log_q[$];

  ngs_boot_tick_master #(.PERIOD(PERIOD), .CONTINUOUS(1'b1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .m_address(m_address),
    .m_chipselect(m_chipselect),
    .m_write_n(m_write_n),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest),
    .irq(irq),
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
    .snap_req(snap_req),
    .snap_valid(snap_valid),
    .snap_value(snap_value),
`endif
    .busy(busy),
    .running(running),
    .tick(tick),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timer slave: latches its counter on a snap write, returns read data one cycle after acceptance,
  // and drops irq when its status register is written.
  always @(posedge clk) begin
    if (m_chipselect && !m_waitrequest && m_write_n)
      m_readdata <= (m_address == 3'd4) ? slave_lat[15:0] :
                    (m_address == 3'd5) ? slave_lat[31:16] : 16'hDEAD;
    else
      m_readdata <= 16'hDEAD;
    if (m_chipselect && !m_waitrequest && !m_write_n && m_address == 3'd4)
      slave_lat <= TIMER_NOW;
    if (irq_clr)
      irq <= 1'b0;
    else if (m_chipselect && !m_waitrequest && !m_write_n && m_address == 3'd0)
      irq <= 1'b0;
    else if (irq_req)
      irq <= 1'b1;
  end

  // Model built from accepted transactions: status write => tick, control START/STOP => running.
  logic        run_e, tick_e, idle_e, hold_v;
  logic [31:0] cnt_e;
  logic [20:0] hold_bus;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
  logic        sv_d1, sv_d2;
  logic [31:0] snapv_e;
  int          snap_pulses = 0;
`endif

  always @(negedge clk) begin
    logic acc, start_hit;
    if (!reset_n) begin
      run_e = 1'b0; tick_e = 1'b0; idle_e = 1'b1; hold_v = 1'b0; cnt_e = '0;
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      sv_d1 = 1'b0; sv_d2 = 1'b0; snapv_e = '0;
`endif
    end else begin
      check("tick", 32'(tick), 32'(tick_e));
      check("tick_count", tick_count, cnt_e);
      check("running", 32'(running), 32'(run_e));
      if (tick) tick_seen++;
      if (!m_chipselect)
        check("idle bus", 32'({m_address, m_write_n, m_writedata}), 32'({3'd0, 1'b1, 16'h0000}));
      if (hold_v)
        check("stall hold", 32'({m_chipselect, m_address, m_write_n, m_writedata}), 32'(hold_bus));
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      if (sv_d2) snapv_e = slave_lat;
      check("snap_valid", 32'(snap_valid), 32'(sv_d2));
      check("snap_value", snap_value, snapv_e);
      if (snap_valid) snap_pulses++;
`endif
      // Predict the effect of the coming edge.
      acc       = m_chipselect && !m_waitrequest;
      start_hit = idle_e && start;
      tick_e    = 1'b0;
      hold_v    = m_chipselect && m_waitrequest;
      hold_bus  = {m_chipselect, m_address, m_write_n, m_writedata};
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
      sv_d2 = sv_d1;
      sv_d1 = acc && m_write_n && m_address == 3'd5;
`endif
      if (acc) begin
        log_q.push_back('{cyc: cyc, addr: m_address, wr: !m_write_n, data: m_writedata});
        if (!m_write_n && m_address == 3'd0) begin
          tick_e = 1'b1;
          cnt_e  = cnt_e + 32'd1;
        end
        if (!m_write_n && m_address == 3'd1 && m_writedata[2]) run_e = 1'b1;
        if (!m_write_n && m_address == 3'd1 && m_writedata[3]) begin
          run_e  = 1'b0;
          idle_e = 1'b1;
        end
      end
      if (start_hit) begin
        cnt_e  = '0;
        idle_e = 1'b0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int n);
    while (cyc < n) step();
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_txn(string nm, int idx, logic [2:0] a, logic wr, logic [15:0] d, int c);
    if (idx >= log_q.size()) begin
      check({nm, " present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({nm, " addr"}, 32'(log_q[idx].addr), 32'(a));
      check({nm, " write"}, 32'(log_q[idx].wr), 32'(wr));
      if (wr) check({nm, " data"}, 32'(log_q[idx].data), 32'(d));
      if (c >= 0) check({nm, " cycle"}, 32'(log_q[idx].cyc), 32'(c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c, base, t0;

    // Reset state
    repeat (3) step();
    check("rst cs", 32'(m_chipselect), 32'd0);
    check("rst write_n", 32'(m_write_n), 32'd1);
    check("rst addr", 32'(m_address), 32'd0);
    check("rst wdata", 32'(m_writedata), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst running", 32'(running), 32'd0);
    check("rst tick_count", tick_count, 32'd0);
`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
    check("rst snap_valid", 32'(snap_valid), 32'd0);
    check("rst snap_value", snap_value, 32'd0);
`endif
    reset_n = 1'b1;
    repeat (2) step();

    // Plain configuration, no wait states
    base = log_q.size();
    pulse_start(s);
    check("t1 busy cfg", 32'(busy), 32'd1);
    wait_until(s + 3);
    check("t1 running c3", 32'(running), 32'd0);
    wait_until(s + 4);
    check("t1 running c4", 32'(running), 32'd1);
    wait_until(s + 6);
    check_txn("t1 pl", base, 3'd2, 1'b1, 16'h61A7, s + 1);
    check_txn("t1 ph", base + 1, 3'd3, 1'b1, 16'h0000, s + 2);
    check_txn("t1 ctl", base + 2, 3'd1, 1'b1, 16'h0007, s + 3);
    check("t1 txn count", 32'(log_q.size() - base), 32'd3);
    check("t1 busy run", 32'(busy), 32'd0);

    // Plain stop from RUN
    base = log_q.size();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    check_txn("stop halt", base, 3'd1, 1'b1, 16'h0008, -1);
    check("stop running", 32'(running), 32'd0);

    // Waitrequest held three cycles on the period_h write
    base = log_q.size();
    pulse_start(s);
    wait_until(s + 2);
    m_waitrequest = 1'b1;
    wait_until(s + 5);
    m_waitrequest = 1'b0;
    wait_until(s + 8);
    check_txn("t2 pl", base, 3'd2, 1'b1, 16'h61A7, s + 1);
    check_txn("t2 ph", base + 1, 3'd3, 1'b1, 16'h0000, s + 5);
    check_txn("t2 ctl", base + 2, 3'd1, 1'b1, 16'h0007, s + 6);
    check("t2 txn count", 32'(log_q.size() - base), 32'd3);

    // Three interrupts serviced
    base = log_q.size();
    t0 = tick_seen;
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      irq_req = 1'b1;
      step();
      irq_req = 1'b0;
      repeat (6) step();
      check_txn("t3 ack", base + i, 3'd0, 1'b1, 16'h0000, c + 2);
    end
    check("t3 tick pulses", 32'(tick_seen - t0), 32'd3);
    check("t3 tick_count", tick_count, 32'd3);

    // Start while running is dropped
    base = log_q.size();
    pulse_start(s);
    repeat (4) step();
    check("t3 start dropped", 32'(log_q.size() - base), 32'd0);
    check("t3 count kept", tick_count, 32'd3);

    // stop and irq in the same RUN cycle
    base = log_q.size();
    irq_req = 1'b1;
    step();
    irq_req = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    check("t4 txn count", 32'(log_q.size() - base), 32'd1);
    check_txn("t4 halt", base, 3'd1, 1'b1, 16'h0008, -1);
    check("t4 running", 32'(running), 32'd0);
    check("t4 tick_count", tick_count, 32'd3);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    step();

    // stop during CFG_PH
    base = log_q.size();
    pulse_start(s);
    wait_until(s + 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_until(s + 7);
    check_txn("t5 pl", base, 3'd2, 1'b1, 16'h61A7, s + 1);
    check_txn("t5 ph", base + 1, 3'd3, 1'b1, 16'h0000, s + 2);
    check_txn("t5 halt", base + 2, 3'd1, 1'b1, 16'h0008, s + 3);
    check("t5 txn count", 32'(log_q.size() - base), 32'd3);
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 tick_count", tick_count, 32'd0);

    // Reset in the middle of a configuration write
    pulse_start(s);
    wait_until(s + 2);
    reset_n = 1'b0;
    #1;
    check("t6 cs", 32'(m_chipselect), 32'd0);
    check("t6 addr", 32'(m_address), 32'd0);
    check("t6 wdata", 32'(m_writedata), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

`ifdef NGS_BOOT_TICK_MASTER_SNAP_EN
    // Snapshot of the timer counter
    pulse_start(s);
    wait_until(s + 6);
    check("t7 running", 32'(running), 32'd1);
    base = log_q.size();
    c = cyc;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    wait_until(c + 6);
    check("t7 snap_valid hi", 32'(snap_valid), 32'd1);
    check("t7 snap_value", snap_value, 32'h0001_2345);
    step();
    check("t7 snap_valid lo", 32'(snap_valid), 32'd0);
    check_txn("t7 latch", base, 3'd4, 1'b1, 16'h0000, c + 1);
    check_txn("t7 read lo", base + 1, 3'd4, 1'b0, 16'h0000, c + 2);
    check_txn("t7 read hi", base + 2, 3'd5, 1'b0, 16'h0000, c + 4);
    check("t7 pulses", 32'(snap_pulses), 32'd1);
`endif

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
